// File: rtl/cpu_adr_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_adr_seq
// Purpose  : Addressing-mode sequencer. Fetches operand/pointer bytes, bumps
//            the PC and produces the 16-bit effective address or branch
//            target for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_adr_seq #(
    parameter logic IDX_Y = 1'b1,   // index value that selects the Y register
    parameter int   ADR_W = 16      // bus / EA width, only 16 is supported
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       adr_mode,
    input  logic             index,
    input  logic [7:0]       reg_x,
    input  logic [7:0]       reg_y,
    input  logic [ADR_W-1:0] pc,
    input  logic             cond_true,
    input  logic [7:0]       data_in,
    output logic [ADR_W-1:0] addr,
    output logic             rd,
    output logic             pc_inc,
    output logic             busy,
    output logic             done,
    output logic [ADR_W-1:0] ea,
    output logic             ea_valid,
    output logic             inval
);

    // Addressing-mode codes from the decoder
    localparam logic [4:0] c_ADR_IMPL       = 5'd0;
    localparam logic [4:0] c_ADR_ACCUM      = 5'd1;
    localparam logic [4:0] c_ADR_IMM        = 5'd2;
    localparam logic [4:0] c_ADR_ZPG        = 5'd3;
    localparam logic [4:0] c_ADR_ZPG_RMW    = 5'd4;
    localparam logic [4:0] c_ADR_ZPG_X_Y    = 5'd5;
    localparam logic [4:0] c_ADR_ZPG_X_RMW  = 5'd6;
    localparam logic [4:0] c_ADR_ABS        = 5'd7;
    localparam logic [4:0] c_ADR_ABS_RMW    = 5'd8;
    localparam logic [4:0] c_ADR_ABS_X_Y    = 5'd9;
    localparam logic [4:0] c_ADR_ABS_X_RMW  = 5'd10;
    localparam logic [4:0] c_ADR_ABS_X_IND  = 5'd11;
    localparam logic [4:0] c_ADR_ZPG_IND_Y  = 5'd12;
    localparam logic [4:0] c_ADR_ABS_IND    = 5'd13;
    localparam logic [4:0] c_ADR_REL        = 5'd14;
    localparam logic [4:0] c_ADR_STACK_PUSH = 5'd15;
    localparam logic [4:0] c_ADR_STACK_PULL = 5'd16;
    localparam logic [4:0] c_ADR_ABS_JSR    = 5'd17;
    localparam logic [4:0] c_ADR_INVAL      = 5'd31;

    // Sequencer states
    localparam logic [3:0] c_ST_IDLE = 4'd0;
    localparam logic [3:0] c_ST_OP1  = 4'd1;
    localparam logic [3:0] c_ST_OP2  = 4'd2;
    localparam logic [3:0] c_ST_IDX  = 4'd3;
    localparam logic [3:0] c_ST_PLO  = 4'd4;
    localparam logic [3:0] c_ST_PHI  = 4'd5;
    localparam logic [3:0] c_ST_BR   = 4'd6;
    localparam logic [3:0] c_ST_FIX  = 4'd7;
    localparam logic [3:0] c_ST_DONE = 4'd8;

    logic [3:0]  r_state;
    logic [3:0]  w_next;
    logic [4:0]  r_mode;
    logic [7:0]  r_idx;      // index value latched at start
    logic [7:0]  r_lo;       // operand low byte, later pointer-read low byte
    logic [15:0] r_ptr;      // indirect pointer address
    logic [15:0] r_ea;
    logic        r_carry;    // FIX must increment the EA high byte
    logic        r_eav;
    logic        r_inval;

    logic [8:0]  w_lo_sum;
    logic [15:0] w_ptr_next;
    logic [15:0] w_target;
    logic        w_seq;      // mode needs at least one bus cycle

    assign w_lo_sum   = {1'b0, r_lo} + {1'b0, r_idx};
    // Pointer high byte never carries: page-0 wrap and the JMP-indirect bug
    assign w_ptr_next = {r_ptr[15:8], r_ptr[7:0] + 8'd1};
    // pc already points past the offset byte when BR is active
    assign w_target   = pc + {{8{r_lo[7]}}, r_lo};

    // Classify modes that are actually sequenced here
    always_comb begin
        w_seq = 1'b0;
        case (adr_mode)
            c_ADR_IMM, c_ADR_ZPG, c_ADR_ZPG_RMW, c_ADR_ZPG_X_Y, c_ADR_ZPG_X_RMW,
            c_ADR_ABS, c_ADR_ABS_RMW, c_ADR_ABS_X_Y, c_ADR_ABS_X_RMW,
            c_ADR_ABS_X_IND, c_ADR_ZPG_IND_Y, c_ADR_ABS_IND, c_ADR_REL:
                w_seq = 1'b1;
            default: w_seq = 1'b0;
        endcase
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next = w_seq ? c_ST_OP1 : c_ST_DONE;
                end
            end
            c_ST_OP1: begin
                case (r_mode)
                    c_ADR_ZPG_X_Y, c_ADR_ZPG_X_RMW, c_ADR_ABS_X_IND:
                        w_next = c_ST_IDX;
                    c_ADR_ABS, c_ADR_ABS_RMW, c_ADR_ABS_X_Y, c_ADR_ABS_X_RMW,
                    c_ADR_ABS_IND:
                        w_next = c_ST_OP2;
                    c_ADR_ZPG_IND_Y:
                        w_next = c_ST_PLO;
                    c_ADR_REL:
                        w_next = cond_true ? c_ST_BR : c_ST_DONE;
                    default:
                        w_next = c_ST_DONE;
                endcase
            end
            c_ST_OP2: begin
                case (r_mode)
                    c_ADR_ABS_X_Y:   w_next = w_lo_sum[8] ? c_ST_FIX : c_ST_DONE;
                    c_ADR_ABS_X_RMW: w_next = c_ST_FIX;
                    c_ADR_ABS_IND:   w_next = c_ST_PLO;
                    default:         w_next = c_ST_DONE;
                endcase
            end
            c_ST_IDX:  w_next = (r_mode == c_ADR_ABS_X_IND) ? c_ST_PLO : c_ST_DONE;
            c_ST_PLO:  w_next = c_ST_PHI;
            c_ST_PHI:  w_next = ((r_mode == c_ADR_ZPG_IND_Y) && w_lo_sum[8]) ?
                                c_ST_FIX : c_ST_DONE;
            c_ST_BR:   w_next = (w_target[15:8] != pc[15:8]) ? c_ST_FIX : c_ST_DONE;
            c_ST_FIX:  w_next = c_ST_DONE;
            c_ST_DONE: w_next = c_ST_IDLE;
            default:   w_next = c_ST_IDLE;
        endcase
    end

    // State, captured bytes and effective-address datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_mode  <= 5'd0;
            r_idx   <= 8'd0;
            r_lo    <= 8'd0;
            r_ptr   <= 16'd0;
            r_ea    <= 16'd0;
            r_carry <= 1'b0;
            r_eav   <= 1'b0;
            r_inval <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_mode  <= adr_mode;
                        r_idx   <= (index == IDX_Y) ? reg_y : reg_x;
                        r_carry <= 1'b0;
                        r_eav   <= w_seq && (adr_mode != c_ADR_REL);
                        r_inval <= (adr_mode == c_ADR_INVAL);
                    end
                end
                c_ST_OP1: begin
                    r_lo <= data_in;
                    case (r_mode)
                        c_ADR_IMM:                 r_ea  <= pc;
                        c_ADR_ZPG, c_ADR_ZPG_RMW:  r_ea  <= {8'h00, data_in};
                        c_ADR_ZPG_IND_Y:           r_ptr <= {8'h00, data_in};
                        c_ADR_REL:                 r_eav <= cond_true;
                        default: ;
                    endcase
                end
                c_ST_OP2: begin
                    case (r_mode)
                        c_ADR_ABS_IND: r_ptr <= {data_in, r_lo};
                        c_ADR_ABS_X_Y, c_ADR_ABS_X_RMW: begin
                            r_ea    <= {data_in, w_lo_sum[7:0]};
                            r_carry <= w_lo_sum[8];
                        end
                        default: r_ea <= {data_in, r_lo};
                    endcase
                end
                c_ST_IDX: begin
                    if (r_mode == c_ADR_ABS_X_IND) begin
                        r_ptr <= {8'h00, w_lo_sum[7:0]};
                    end else begin
                        r_ea  <= {8'h00, w_lo_sum[7:0]};
                    end
                end
                c_ST_PLO: r_lo <= data_in;
                c_ST_PHI: begin
                    if (r_mode == c_ADR_ZPG_IND_Y) begin
                        r_ea    <= {data_in, w_lo_sum[7:0]};
                        r_carry <= w_lo_sum[8];
                    end else begin
                        r_ea    <= {data_in, r_lo};
                    end
                end
                c_ST_BR:  r_ea <= w_target;
                c_ST_FIX: begin
                    if (r_carry) begin
                        r_ea[15:8] <= r_ea[15:8] + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus drive and status decoded from the current state
    always_comb begin
        addr   = 16'h0000;
        rd     = 1'b0;
        pc_inc = 1'b0;
        case (r_state)
            c_ST_OP1, c_ST_OP2: begin
                addr   = pc;
                rd     = 1'b1;
                pc_inc = 1'b1;
            end
            c_ST_PLO: begin
                addr = r_ptr;
                rd   = 1'b1;
            end
            c_ST_PHI: begin
                addr = w_ptr_next;
                rd   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (r_state != c_ST_IDLE);
    assign done     = (r_state == c_ST_DONE);
    assign ea       = r_ea;
    assign ea_valid = done && r_eav;
    assign inval    = done && r_inval;

endmodule
`default_nettype wire

// File: doc/cpu_adr_seq.md
Name: cpu_adr_seq

Overview:
- Addressing-mode sequencer directly downstream of the CPU instruction decoder.
- Consumes the decoder's 5-bit adr_mode and index-select outputs. Issues operand and pointer bus reads, advances PC, and computes the 16-bit effective address (EA) or branch target.
- Execute logic uses the EA when done pulses.
- Stack, JSR and invalid modes are not sequenced here; they complete immediately and are handed off.

Parameters:
- IDX_Y, 1'b1, value of index input selecting Y; equals `ADR_INDEX_Y from config.vh.
- ADR_W, 16, bus/EA width; the only supported value is 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; adr_mode/index valid with it.
- adr_mode  in  5  decoder addressing mode, `ADR_* codes from config.vh.
- index  in  1  index register select (X or Y).
- reg_x  in  8  X register.
- reg_y  in  8  Y register.
- pc  in  16  current PC; already reflects prior pc_inc pulses.
- cond_true  in  1  branch condition result, sampled in the OP1 cycle of REL.
- data_in  in  8  bus read data, captured at the end of the cycle that drives addr.
- addr  out  16  bus address.
- rd  out  1  bus read strobe.
- pc_inc  out  1  advance PC by 1 at the end of this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- ea  out  16  effective address / branch target; valid while done is high and held afterwards.
- ea_valid  out  1  qualifies ea with done; 0 for IMPL/ACCUM/stack/JSR/INVAL and for a not-taken REL.
- inval  out  1  pulses with done when adr_mode=`ADR_INVAL.

Behaviour:
- States: IDLE, OP1, OP2, IDX, PLO, PHI, BR, FIX, DONE.
- Reset (async, rst_n=0): state IDLE; addr=0, rd=0, pc_inc=0, busy=0, done=0, ea=0, ea_valid=0, inval=0. Reset mid-sequence aborts with no further bus activity.
- In IDLE, start=1 latches adr_mode, index and the selected index value, then moves to the first state below. start while busy is ignored.
- addr/rd by state; all other states drive addr=0, rd=0:
  - OP1, OP2: addr=pc, rd=1, pc_inc=1.
  - PLO: addr=ptr, rd=1.
  - PHI: addr=ptr_next, rd=1.
- Every sequence ends in DONE (one cycle: done=1, then IDLE). Latency is counted in cycles after the start edge, with DONE as the last cycle.
- IMPL/ACCUM/STACK_*/ABS_JSR/INVAL: DONE; L=1; ea_valid=0.
- IMM: OP1 (ea<=pc), DONE; L=2.
- ZPG, ZPG_RMW: OP1, DONE; ea={8'h00,op_lo}; L=2.
- ZPG_X_Y, ZPG_X_RMW: OP1, IDX, DONE; ea={8'h00,(op_lo+idx)[7:0]}; zero-page wrap, no carry; L=3.
- ABS, ABS_RMW: OP1, OP2, DONE; ea={op_hi,op_lo}; L=3.
- ABS_X_Y: OP1, OP2, [FIX], DONE.
  - Low sum = op_lo+idx; FIX is inserted only on carry, and FIX increments the high byte.
  - L=3, or 4 on page cross.
- ABS_X_RMW: same as ABS_X_Y, but FIX is always taken; L=4.
- ABS_X_IND ((zp,X)): OP1, IDX, PLO, PHI, DONE.
  - ptr={00,(op_lo+X)[7:0]}; ptr_next={00,ptr[7:0]+1} (wraps in page 0); ea={hi,lo}; L=5.
- ZPG_IND_Y ((zp),Y): OP1, PLO, PHI, [FIX], DONE.
  - ptr={00,op_lo}; ptr_next={00,op_lo+1} (page-0 wrap); ea={hi,lo}+Y.
  - FIX is inserted only on low-byte carry; L=4 or 5.
- ABS_IND (JMP ind): OP1, OP2, PLO, PHI, DONE.
  - ptr={op_hi,op_lo}; ptr_next={op_hi,op_lo+1} (NMOS page-wrap bug reproduced); L=5.
- REL:
  - OP1 fetches the offset and samples cond_true.
  - Not taken: DONE, ea_valid=0; L=2.
  - Taken: BR computes target=pc+sext(offset) (pc already incremented). A page change vs pc adds FIX. ea=target, ea_valid=1; L=3 or 4.
- All address arithmetic is modulo 2^16.
- index selects reg_y when index==IDX_Y, else reg_x. The value is latched at start and is not re-sampled.

Test Plan:
- Reset: assert rst_n=0 mid-ABS_IND at PLO -> next cycle addr=0, rd=0, busy=0, done=0, ea=0; a later start behaves normally.
- ABS_X_Y: pc=0x0200, mem[0200]=0xF0, mem[0201]=0x12, X=0x20 -> reads 0200, 0201; FIX taken; done at cycle 4; ea=0x1310, ea_valid=1. Repeat with X=0x05 -> done at cycle 3; ea=0x12F5.
- ZPG_X_Y wrap: operand 0xFF, X=0x02 -> ea=0x0001; L=3; no bus read in IDX.
- ZPG_IND_Y:
  - op=0xFF, mem[00FF]=0x80, mem[0000]=0x40, Y=0x90 -> PLO addr 00FF, PHI addr 0000; ea=0x4110; L=5.
  - Same with Y=0x10 -> ea=0x4090; L=4.
- ABS_IND bug: pointer 0x30FF -> PLO addr 30FF, PHI addr 3000 (not 3100); L=5.
- REL:
  - pc=0x10FE, offset 0x05, cond_true=1 -> after OP1 pc=0x10FF; target=0x1104; page cross, L=4.
  - cond_true=0 -> L=2, ea_valid=0.
  - start pulsed while busy -> ignored.
  - INVAL -> done and inval at cycle 1.
